// File: rtl/mem_arbiter_pkg.sv
// Shared types for the byte-wide memory port arbiter: FSM states, grant owner, access-size decode.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    MA_IDLE,
    MA_IFETCH,
    MA_LOAD,
    MA_STORE,
    MA_GAP
  } ma_state_t;

  typedef enum logic {
    GRANT_IC  = 1'b0,
    GRANT_LSB = 1'b1
  } grant_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [2:0] IC_BYTES  = 3'd4;

  // Size code 3 is not a legal access; it is handled as a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Owns the byte-wide RAM/IO port: round-robin between icache refills and LSB accesses,
// sequencing each as 1/2/4 byte cycles; reads finish at cycle n, writes at cycle n-1.
module mem_arbiter #(
  parameter logic [31:0] IO_BASE  = 32'h0003_0000,
  parameter int          IDLE_GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        io_buffer_full,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din
);
  import mem_arbiter_pkg::*;

  ma_state_t   state;
  grant_t      last_grant;
  logic [2:0]  cnt;
  logic [2:0]  n_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [7:0]  gap_cnt;

  logic        pick_ic;
  logic        pick_lsb;
  ma_state_t   grant_st;
  logic [31:0] g_addr;
  logic [2:0]  g_n;
  logic        g_io_stall;
  logic        io_stall;
  logic [1:0]  cap_idx;
  logic [31:0] rd_word;

  // While flushing only a committed store may start; speculative traffic waits.
  always_comb begin
    pick_ic  = 1'b0;
    pick_lsb = 1'b0;
    if (flush) begin
      pick_lsb = lsb_req & lsb_we;
    end else if (ic_req & lsb_req) begin
      pick_lsb = (last_grant == GRANT_IC);
      pick_ic  = ~pick_lsb;
    end else begin
      pick_ic  = ic_req;
      pick_lsb = lsb_req;
    end

    grant_st = MA_IDLE;
    if (pick_ic)       grant_st = MA_IFETCH;
    else if (pick_lsb) grant_st = lsb_we ? MA_STORE : MA_LOAD;

    g_addr     = pick_ic ? ic_addr : lsb_addr;
    g_n        = pick_ic ? IC_BYTES : size_bytes(lsb_size);
    g_io_stall = (lsb_addr >= IO_BASE) && io_buffer_full;
    io_stall   = (addr_q >= IO_BASE) && io_buffer_full;

    // mem_din carries the byte addressed in the previous cycle.
    cap_idx = 2'(cnt - 3'd1);
    rd_word = data_q;
    rd_word[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MA_IDLE;
      last_grant <= GRANT_IC;
      cnt        <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      gap_cnt    <= '0;
      ic_done    <= 1'b0;
      lsb_done   <= 1'b0;
      mem_wr     <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= '0;
      ic_data    <= '0;
      lsb_rdata  <= '0;
    end else if (rdy) begin
      ic_done  <= 1'b0;
      lsb_done <= 1'b0;
      mem_wr   <= 1'b0;
      case (state)
        MA_IDLE: begin
          if (grant_st != MA_IDLE) begin
            state      <= grant_st;
            last_grant <= (grant_st == MA_IFETCH) ? GRANT_IC : GRANT_LSB;
            addr_q     <= g_addr;
            n_q        <= g_n;
            wdata_q    <= lsb_wdata;
            data_q     <= '0;
            mem_a      <= g_addr;
            cnt        <= 3'd1;
            if (grant_st == MA_STORE) begin
              if (g_io_stall) begin
                cnt <= 3'd0;
              end else begin
                mem_wr   <= 1'b1;
                mem_dout <= lsb_wdata[7:0];
                lsb_done <= (g_n == 3'd1);
              end
            end
          end
        end
        MA_IFETCH, MA_LOAD: begin
          if (flush) begin
            state   <= MA_GAP;
            gap_cnt <= '0;
          end else begin
            data_q <= rd_word;
            if (cnt == n_q) begin
              state   <= MA_GAP;
              gap_cnt <= '0;
              if (state == MA_IFETCH) begin
                ic_done <= 1'b1;
                ic_data <= rd_word;
              end else begin
                lsb_done  <= 1'b1;
                lsb_rdata <= rd_word;
              end
            end else begin
              mem_a <= addr_q + 32'(cnt);
              cnt   <= cnt + 3'd1;
            end
          end
        end
        MA_STORE: begin
          if (cnt == n_q) begin
            state   <= MA_GAP;
            gap_cnt <= '0;
          end else if (!io_stall) begin
            mem_a    <= addr_q + 32'(cnt);
            mem_wr   <= 1'b1;
            mem_dout <= wdata_q[{cnt[1:0], 3'b000} +: 8];
            cnt      <= cnt + 3'd1;
            lsb_done <= (cnt + 3'd1 == n_q);
          end
        end
        MA_GAP: begin
          if (int'(gap_cnt) + 1 >= IDLE_GAP) state <= MA_IDLE;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= MA_IDLE;
      endcase
    end
  end

endmodule
